// File: rtl/ex_pkg.sv
// ex_pkg: shared types and decode helper for the execute stage.
//   XLEN        datapath width (only 32 is supported)
//   alu_op_t    4-bit ALU op code as consumed by the existing ALU
//   F3_*        RISC-V integer funct3 encodings
//   ex_entry_t  one registered result {result, rd, illegal}
//   decode_op   funct3/funct7b5/use_imm -> alu_op_t
package ex_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD     = 4'b0000,
        ALU_SUB     = 4'b0001,
        ALU_SLL     = 4'b0010,
        ALU_SLT     = 4'b0011,
        ALU_SLTU    = 4'b0100,
        ALU_XOR     = 4'b0101,
        ALU_SRL     = 4'b0110,
        ALU_SRA     = 4'b0111,
        ALU_OR      = 4'b1000,
        ALU_AND     = 4'b1001,
        ALU_ILLEGAL = 4'b1111
    } alu_op_t;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [4:0]      rd;
        logic            illegal;
    } ex_entry_t;

    function automatic alu_op_t decode_op(input logic [2:0] funct3,
                                          input logic       funct7b5,
                                          input logic       use_imm);
        alu_op_t op;
        case (funct3)
            F3_ADD:  op = (funct7b5 && !use_imm) ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = funct7b5 ? ALU_ILLEGAL : ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = funct7b5 ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        // On I-type, bit 30 is part of the immediate for everything but the
        // shifts, so only R-type rejects it outside add/sub and the right shifts.
        if (funct7b5 && !use_imm && funct3 != F3_ADD && funct3 != F3_SR) begin
            op = ALU_ILLEGAL;
        end
        return op;
    endfunction

endpackage

// File: rtl/alu.sv
// alu: existing combinational integer ALU used by the execute stage.
//   op      4-bit op code (unknown codes produce 0)
//   a, b    operands
//   result  combinational result
module alu (
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);

    always_comb begin
        result = '0;
        case (op)
            4'b0000: result = a + b;
            4'b0001: result = a - b;
            4'b0010: result = a << b[4:0];
            4'b0011: result = {31'b0, $signed(a) < $signed(b)};
            4'b0100: result = {31'b0, a < b};
            4'b0101: result = a ^ b;
            4'b0110: result = a >> b[4:0];
            4'b0111: result = $signed(a) >>> b[4:0];
            4'b1000: result = a | b;
            4'b1001: result = a & b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/ex_skid_buf.sv
// ex_skid_buf: 2-entry valid/ready buffer of ex_entry_t with synchronous flush.
//   clk, rst_n            clock, async active-low reset
//   flush                 drops both entries and any op accepted this cycle
//   in_valid/in_ready     upstream handshake (in_ready = skid entry empty)
//   in_data               entry to store
//   out_valid/out_ready   downstream handshake, driven from the main entry
//   out_data              main entry payload (held while not valid)
//   skid_valid/skid_data  newer held entry, exposed for operand forwarding
module ex_skid_buf
    import ex_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    input  logic      in_valid,
    output logic      in_ready,
    input  ex_entry_t in_data,
    output logic      out_valid,
    input  logic      out_ready,
    output ex_entry_t out_data,
    output logic      skid_valid,
    output ex_entry_t skid_data
);

    logic      main_v_q, main_v_d;
    logic      skid_v_q, skid_v_d;
    ex_entry_t main_q, main_d;
    ex_entry_t skid_q, skid_d;
    logic      accept;

    assign in_ready   = !skid_v_q;
    assign accept     = in_valid && in_ready;
    assign out_valid  = main_v_q;
    assign out_data   = main_q;
    assign skid_valid = skid_v_q;
    assign skid_data  = skid_q;

    always_comb begin
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        main_d   = main_q;
        skid_d   = skid_q;
        if (flush) begin
            // Payload registers are left alone so the outputs hold their last value.
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (!main_v_q || out_ready) begin
            // Main slot frees up this cycle: the older skid entry moves up first.
            // A valid skid entry implies in_ready=0, so no accept can collide.
            if (skid_v_q) begin
                main_d   = skid_q;
                main_v_d = 1'b1;
                skid_v_d = 1'b0;
            end else if (accept) begin
                main_d   = in_data;
                main_v_d = 1'b1;
            end else begin
                main_v_d = 1'b0;
            end
        end else if (accept) begin
            skid_d   = in_data;
            skid_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
        end else begin
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: integer execute stage. Selects operands, decodes funct3/funct7b5
// to an ALU op, masks shift amounts, and registers the ALU result into a
// 2-entry skid buffer toward memory/writeback.
//   clk, rst_n                  clock, async active-low reset
//   flush                       discard held and incoming ops
//   in_valid/in_ready           decode handshake
//   in_rs1_val/in_rs2_val       register operands
//   in_rs1_idx/in_rs2_idx       source indices (forwarding only)
//   in_imm, in_use_imm          immediate and operand-b select
//   in_funct3, in_funct7b5      instruction function bits
//   in_rd                       destination register
//   out_valid/out_ready         result handshake
//   out_result/out_rd/out_illegal  registered result
// Build option: EX_FWD_EN enables forwarding of held results to operands.
module ex_stage
    import ex_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    input  logic [4:0]      in_rs1_idx,
    input  logic [4:0]      in_rs2_idx,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_use_imm,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7b5,
    input  logic [4:0]      in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd,
    output logic            out_illegal
);

    alu_op_t         alu_op;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b_raw;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_result;
    ex_entry_t       in_entry;
    ex_entry_t       main_entry;
    ex_entry_t       skid_entry;
    logic            skid_valid;

    assign alu_op = decode_op(in_funct3, in_funct7b5, in_use_imm);

`ifdef EX_FWD_EN
    always_comb begin
        op_a     = in_rs1_val;
        op_b_raw = in_use_imm ? in_imm : in_rs2_val;
        if (out_valid && main_entry.rd != 5'd0) begin
            if (in_rs1_idx == main_entry.rd) op_a = main_entry.result;
            if (!in_use_imm && in_rs2_idx == main_entry.rd) op_b_raw = main_entry.result;
        end
        // Skid entry is younger than the main entry, so it overrides.
        if (skid_valid && skid_entry.rd != 5'd0) begin
            if (in_rs1_idx == skid_entry.rd) op_a = skid_entry.result;
            if (!in_use_imm && in_rs2_idx == skid_entry.rd) op_b_raw = skid_entry.result;
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{in_rs1_idx, in_rs2_idx, skid_valid, skid_entry};

    always_comb begin
        op_a     = in_rs1_val;
        op_b_raw = in_use_imm ? in_imm : in_rs2_val;
    end
`endif

    always_comb begin
        op_b = op_b_raw;
        if (alu_op == ALU_SLL || alu_op == ALU_SRL || alu_op == ALU_SRA) begin
            op_b = {27'b0, op_b_raw[4:0]};
        end
    end

    alu u_alu (
        .op     (alu_op),
        .a      (op_a),
        .b      (op_b),
        .result (alu_result)
    );

    always_comb begin
        in_entry         = '0;
        in_entry.result  = alu_result;
        in_entry.rd      = in_rd;
        in_entry.illegal = (alu_op == ALU_ILLEGAL);
    end

    ex_skid_buf u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_entry),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (main_entry),
        .skid_valid (skid_valid),
        .skid_data  (skid_entry)
    );

    assign out_result  = main_entry.result;
    assign out_rd      = main_entry.rd;
    assign out_illegal = main_entry.illegal;

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_rs1_val = '0, in_rs2_val = '0, in_imm = '0;
    logic [4:0]  in_rs1_idx = '0, in_rs2_idx = '0, in_rd = '0;
    logic        in_use_imm = 1'b0;
    logic [2:0]  in_funct3 = '0;
    logic        in_funct7b5 = 1'b0;
    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_result;
    logic [4:0]  out_rd;

    ex_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rs1_val  (in_rs1_val),
        .in_rs2_val  (in_rs2_val),
        .in_rs1_idx  (in_rs1_idx),
        .in_rs2_idx  (in_rs2_idx),
        .in_imm      (in_imm),
        .in_use_imm  (in_use_imm),
        .in_funct3   (in_funct3),
        .in_funct7b5 (in_funct7b5),
        .in_rd       (in_rd),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_rd      (out_rd),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        illegal;
    } exp_t;

    int          total = 0;
    int          bad = 0;
    exp_t        q[$];
    exp_t        last_head;
    logic [31:0] seen[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural meaning of each RV32I integer op, straight from the ISA rules.
    function automatic logic [32:0] model_exec(input logic [2:0] f3, input logic f7,
                                               input logic imm_sel, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [31:0] r;
        logic        ill;
        ill = f7 && ((!imm_sel && f3 != 3'd0 && f3 != 3'd5) || (imm_sel && f3 == 3'd1));
        r = 32'd0;
        if (!ill) begin
            case (f3)
                3'd0: if (f7 && !imm_sel) r = a - b; else r = a + b;
                3'd1: r = a << b[4:0];
                3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                3'd3: r = (a < b) ? 32'd1 : 32'd0;
                3'd4: r = a ^ b;
                3'd5: if (f7) r = $signed(a) >>> b[4:0]; else r = a >> b[4:0];
                3'd6: r = a | b;
                default: r = a & b;
            endcase
        end
        return {ill, r};
    endfunction

    task automatic set_op(input logic v, input logic [2:0] f3, input logic f7, input logic ui,
                          input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                          input logic [4:0] rd, input logic [4:0] i1, input logic [4:0] i2);
        in_valid = v; in_funct3 = f3; in_funct7b5 = f7; in_use_imm = ui;
        in_rs1_val = rs1; in_rs2_val = rs2; in_imm = imm; in_rd = rd;
        in_rs1_idx = i1; in_rs2_idx = i2;
    endtask

    // One clock: check outputs against the model mid-low-phase, then advance the model.
    task automatic cycle(output logic acc, output logic emit);
        exp_t        e, head;
        logic        exp_rdy;
        logic [31:0] a, b;
        logic [32:0] res;
        #1;
        exp_rdy = (q.size() < 2);
        if (q.size() != 0) head = q[0]; else head = last_head;
        chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
        chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
        chk("out_result", out_result, head.result);
        chk("out_rd", {27'b0, out_rd}, {27'b0, head.rd});
        chk("out_illegal", {31'b0, out_illegal}, {31'b0, head.illegal});
        acc  = in_valid && exp_rdy;
        emit = (q.size() != 0) && out_ready;
        if (emit) seen.push_back(out_result);
        a = in_rs1_val;
        b = in_use_imm ? in_imm : in_rs2_val;
`ifdef EX_FWD_EN
        // The newest pending write to a register is the value a reader must see.
        foreach (q[i]) begin
            if (q[i].rd != 5'd0 && q[i].rd == in_rs1_idx) a = q[i].result;
            if (!in_use_imm && q[i].rd != 5'd0 && q[i].rd == in_rs2_idx) b = q[i].result;
        end
`endif
        res = model_exec(in_funct3, in_funct7b5, in_use_imm, a, b);
        e.result  = res[31:0];
        e.illegal = res[32];
        e.rd      = in_rd;
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (emit) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        if (q.size() != 0) last_head = q[0];
        @(negedge clk);
    endtask

    initial begin
        logic acc, emit, pend;
        int   n_acc, n_emit;
        logic [31:0] r32;

        last_head.result = '0; last_head.rd = '0; last_head.illegal = 1'b0;

        // Reset values
        #2;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_rd", {27'b0, out_rd}, 32'd0);
        chk("rst_out_illegal", {31'b0, out_illegal}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;

        // R-type sub
        set_op(1, 3'b000, 1, 0, 32'd5, 32'd7, 32'd0, 5'd1, 5'd0, 5'd0);
        cycle(acc, emit);
        in_valid = 1'b0;
        chk("sub_result", out_result, 32'hFFFF_FFFE);
        chk("sub_illegal", {31'b0, out_illegal}, 32'd0);
        cycle(acc, emit);

        // I-type srai with bit 10 set in the immediate
        set_op(1, 3'b101, 1, 1, 32'h8000_0000, 32'd0, 32'h0000_0404, 5'd2, 5'd0, 5'd0);
        cycle(acc, emit);
        in_valid = 1'b0;
        chk("srai_result", out_result, 32'hF800_0000);
        cycle(acc, emit);

        // Illegal R-type or with funct7b5
        set_op(1, 3'b110, 1, 0, 32'h1234_5678, 32'hFFFF_0000, 32'd0, 5'd3, 5'd0, 5'd0);
        cycle(acc, emit);
        in_valid = 1'b0;
        chk("illegal_result", out_result, 32'd0);
        chk("illegal_flag", {31'b0, out_illegal}, 32'd1);
        cycle(acc, emit);

        // Backpressure: 3 adds with out_ready low
        out_ready = 1'b0;
        n_acc = 0;
        seen.delete();
        set_op(1, 3'b000, 0, 0, 32'd100, 32'd1, 32'd0, 5'd5, 5'd0, 5'd0);
        for (int k = 0; k < 6 && n_acc < 2; k++) begin
            cycle(acc, emit);
            if (acc) begin
                n_acc++;
                set_op(1, 3'b000, 0, 0, 32'd100 * (n_acc + 1), 32'd1, 32'd0, 5'(5 + n_acc), 5'd0, 5'd0);
            end
        end
        chk("bp_full_in_ready", {31'b0, in_ready}, 32'd0);
        cycle(acc, emit);
        chk("bp_no_accept_when_full", {31'b0, acc}, 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 10 && n_acc < 3; k++) begin
            cycle(acc, emit);
            if (acc) begin
                n_acc++;
                in_valid = 1'b0;
            end
        end
        for (int k = 0; k < 4; k++) cycle(acc, emit);
        chk("bp_emit_count", seen.size(), 32'd3);
        if (seen.size() == 3) begin
            chk("bp_order0", seen[0], 32'd101);
            chk("bp_order1", seen[1], 32'd201);
            chk("bp_order2", seen[2], 32'd301);
        end

        // Flush with both entries full and an op presented
        out_ready = 1'b0;
        set_op(1, 3'b100, 0, 0, 32'hAAAA_0000, 32'h0000_5555, 32'd0, 5'd9, 5'd0, 5'd0);
        cycle(acc, emit);
        cycle(acc, emit);
        flush = 1'b1;
        cycle(acc, emit);
        flush = 1'b0;
        chk("flush_full_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_full_ready", {31'b0, in_ready}, 32'd1);
        // Flush with one held entry and a same-cycle accept
        cycle(acc, emit);
        flush = 1'b1;
        cycle(acc, emit);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        seen.delete();
        for (int k = 0; k < 3; k++) cycle(acc, emit);
        chk("flush_nothing_emitted", seen.size(), 32'd0);

        // Forwarding of a just-computed rd
        set_op(1, 3'b000, 0, 0, 32'd1, 32'd2, 32'd0, 5'd3, 5'd0, 5'd0);
        cycle(acc, emit);
        set_op(1, 3'b000, 0, 0, 32'd0, 32'd10, 32'd0, 5'd4, 5'd3, 5'd0);
        cycle(acc, emit);
        in_valid = 1'b0;
`ifdef EX_FWD_EN
        chk("fwd_result", out_result, 32'd13);
`else
        chk("fwd_result", out_result, 32'd10);
`endif
        cycle(acc, emit);

        // Asynchronous reset while holding two ops
        out_ready = 1'b0;
        set_op(1, 3'b110, 0, 1, 32'hF0F0_0000, 32'd0, 32'h0000_0F0F, 5'd7, 5'd0, 5'd0);
        cycle(acc, emit);
        cycle(acc, emit);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("async_rst_result", out_result, 32'd0);
        chk("async_rst_ready", {31'b0, in_ready}, 32'd1);
        q.delete();
        last_head.result = '0; last_head.rd = '0; last_head.illegal = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic with stable-until-accepted payloads
        pend = 1'b0;
        n_emit = 0;
        for (int n = 0; n < 500; n++) begin
            if (!pend) begin
                r32 = $urandom;
                set_op($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) == 0) ? 32'h8000_0000 | $urandom_range(0, 255) : $urandom,
                       ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                       {{20{r32[11]}}, r32[11:0]},
                       5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 24) == 0);
            cycle(acc, emit);
            if (emit) n_emit++;
            pend = in_valid && !acc;
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) cycle(acc, emit);
        chk("rand_drained", {31'b0, out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the motor-controller RISC-V core, directly upstream of the combinational ALU. It accepts decoded integer ops from decode over a valid/ready handshake and selects operands (register or immediate). It maps funct3/funct7 to the ALU's 4-bit op code, masks shift amounts, drives the ALU, and registers the result into a 2-entry skid buffer feeding memory/writeback.

## Interface
- XLEN, 32, datapath width; only 32 supported
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous; discards all held and incoming ops
- in_valid  in  1  decode presents an op
- in_ready  out  1  stage can accept this cycle
- in_rs1_val, in_rs2_val  in  32  register operands
- in_rs1_idx, in_rs2_idx  in  5  source indices (used for forwarding)
- in_imm  in  32  sign-extended immediate
- in_use_imm  in  1  1: operand b = in_imm (I-type); 0: b = rs2 (R-type)
- in_funct3  in  3  instruction funct3
- in_funct7b5  in  1  instruction bit 30
- in_rd  in  5  destination register
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts
- out_result  out  32  ALU result
- out_rd  out  5  destination register
- out_illegal  out  1  op decoded as illegal; result is 0

## Operation
- Op map (funct3): 000 add (0000), or sub (0001) when R-type and funct7b5=1. 001 sll (0010). 010 slt (0011). 011 sltu (0100). 100 xor (0101). 101 srl (0110) or sra (0111) by funct7b5. 110 or (1000). 111 and (1001).
- Illegal: funct7b5=1 with funct3 ∉ {000, 101} on R-type, or with funct3=001 on I-type. Drive op 4'b1111, so the ALU default gives 0; set out_illegal.
- I-type funct3=000 ignores funct7b5 (add).
- Shifts: b is masked to b[4:0] before reaching the ALU. Non-shift ops pass b unmasked.
- Handshake: transfer on valid&&ready at either port. in_ready = skid entry empty. in_valid and payload must stay stable until accepted.
- Skid buffer: main entry drives the outputs, skid entry catches one op when out_ready drops. Entries are ordered oldest-first; no reordering.
- Simultaneous accept and drain: throughput 1 op/cycle; occupancy unchanged.
- flush: both entries are invalidated at the next edge, and an op accepted in the same cycle is dropped. flush has priority over every handshake.

## Timing
- Latency: op accepted at edge N appears on out_* after edge N (one cycle).
- Reset values: out_valid=0, out_result=0, out_rd=0, out_illegal=0, both entries invalid. in_ready=1 from the first cycle after rst_n deasserts.
- Reset asserted mid-operation clears all state immediately (asynchronously).
- Full (both entries valid): in_ready=0. It returns to 1 the cycle after out_ready&&out_valid.
- out_* must not change while out_valid=1 and out_ready=0.
- out_* payload is don't-care when out_valid=0, but is held at the last value and never X after reset.

## Configuration
- EX_FWD_EN defined: if the main entry is valid with out_rd≠0, and in_rs1_idx or in_rs2_idx equals out_rd, the ALU uses out_result in place of that operand.
  - rs2 forwarding is suppressed when in_use_imm=1.
  - If the skid entry is also valid, it is the newer value and wins.
- EX_FWD_EN undefined: the operands are used exactly as presented. The idx ports exist but are ignored.

## Structure
- Package ex_pkg holds:
  - alu_op_t (4-bit enum: ADD=0000 … AND=1001, ILLEGAL=1111)
  - funct3 localparams
  - ex_entry_t struct {result, rd, illegal}
- ex_stage instantiates the existing ALU unchanged.
- One new sub-module, ex_skid_buf: a generic 2-entry valid/ready buffer of ex_entry_t with flush.

## Test plan
- R-type sub: rs1=5, rs2=7, funct3=000, funct7b5=1 -> out_result=0xFFFFFFFE one cycle later, out_illegal=0.
- I-type srai: rs1=0x80000000, imm=0x00000404 (shamt 4, bit 10 set), funct3=101, funct7b5=1 -> 0xF8000000. The mask keeps the shift at 4.
- Backpressure: stream 3 adds with out_ready=0 -> in_ready falls after 2 accepts. Raise out_ready -> results emerge in order, no loss, no duplicates.
- Illegal: R-type funct3=110, funct7b5=1 -> out_result=0, out_illegal=1.
- Flush with both entries full plus an in-flight accept -> out_valid=0 next cycle, in_ready=1, nothing further emitted.
- EX_FWD_EN: add x3=1+2, then add x4 with rs1_idx=3 and stale rs1_val=0, rs2=10 -> out_result=13. Without the macro -> 10.
